// File: rtl/rs_encode_framer.sv
// Systematic RS(127,121) encoder over GF(2^7): data symbols pass through with one cycle of latency,
// then NPAR parity symbols are appended from a generator-polynomial LFSR.
module rs_encode_framer #(
  parameter int         K         = 121,
  parameter int         NPAR      = 6,
  parameter logic [7:0] PRIM_POLY = 8'h89
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic       sopIn,
  input  logic       dataInValid,
  input  logic [6:0] dataIn,
  output logic       inReady,
  output logic [6:0] dataOut,
  output logic       dataOutValid,
  output logic       sopOut,
  output logic       eopOut,
  output logic       parityFlag,
  output logic       errOut
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} stateT;

  localparam int             CW        = $clog2(K + 1);
  localparam logic [CW-1:0]  ONE       = CW'(1);
  localparam logic [CW-1:0]  LAST_DATA = CW'(K - 1);
  localparam logic [CW-1:0]  LAST_PAR  = CW'(NPAR - 1);

  function automatic logic [6:0] gfMul(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] acc;
    logic [6:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[5:0], 1'b0} ^ (x[6] ? PRIM_POLY[6:0] : 7'd0);
    end
    return acc;
  endfunction

  // Expands prod_{j<NPAR} (x + a^j) at elaboration; g[i] is the x^i coefficient.
  function automatic logic [6:0] genCoef(input int idx);
    logic [NPAR:0][6:0] g;
    logic [6:0]         root;
    g    = '0;
    g[0] = 7'd1;
    root = 7'd1;
    for (int j = 0; j < NPAR; j++) begin
      for (int i = NPAR; i > 0; i--) g[i] = g[i-1] ^ gfMul(g[i], root);
      g[0] = gfMul(g[0], root);
      root = gfMul(root, 7'd2);
    end
    return g[idx];
  endfunction

  stateT                 state, stateNxt;
  logic [CW-1:0]         symCnt, symCntNxt;
  logic [NPAR-1:0][6:0]  lfsr, lfsrNxt, lfsrStep;
  logic [6:0]            dataOutNxt, fb;
  logic                  validNxt, sopNxt, eopNxt, parNxt, errNxt, accept;

  assign inReady = enable & (state != PARITY);
  assign accept  = enable & dataInValid & inReady;

  // A symbol carrying sopIn always starts from a cleared register.
  assign fb = dataIn ^ (sopIn ? 7'd0 : lfsr[NPAR-1]);

  for (genvar i = 0; i < NPAR; i++) begin : gStep
    localparam logic [6:0] G = genCoef(i);
    if (i == 0) begin : gLow
      assign lfsrStep[i] = gfMul(fb, G);
    end else begin : gHigh
      assign lfsrStep[i] = (sopIn ? 7'd0 : lfsr[i-1]) ^ gfMul(fb, G);
    end
  end

  always_comb begin
    stateNxt   = state;
    symCntNxt  = symCnt;
    lfsrNxt    = lfsr;
    dataOutNxt = dataOut;
    validNxt   = 1'b0;
    sopNxt     = 1'b0;
    eopNxt     = 1'b0;
    parNxt     = 1'b0;
    errNxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && sopIn) begin
          lfsrNxt    = lfsrStep;
          dataOutNxt = dataIn;
          validNxt   = 1'b1;
          sopNxt     = 1'b1;
          symCntNxt  = ONE;
          stateNxt   = DATA;
        end else if (accept) begin
          errNxt = 1'b1;
        end
      end
      DATA: begin
        if (accept) begin
          lfsrNxt    = lfsrStep;
          dataOutNxt = dataIn;
          validNxt   = 1'b1;
          if (sopIn) begin
            errNxt    = 1'b1;
            sopNxt    = 1'b1;
            symCntNxt = ONE;
          end else if (symCnt == LAST_DATA) begin
            symCntNxt = '0;
            stateNxt  = PARITY;
          end else begin
            symCntNxt = symCnt + ONE;
          end
        end
      end
      PARITY: begin
        dataOutNxt = lfsr[NPAR-1];
        validNxt   = 1'b1;
        parNxt     = 1'b1;
        lfsrNxt    = {lfsr[NPAR-2:0], 7'd0};
        if (symCnt == LAST_PAR) begin
          eopNxt    = 1'b1;
          symCntNxt = '0;
          stateNxt  = IDLE;
        end else begin
          symCntNxt = symCnt + ONE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      symCnt       <= '0;
      lfsr         <= '0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
      sopOut       <= 1'b0;
      eopOut       <= 1'b0;
      parityFlag   <= 1'b0;
      errOut       <= 1'b0;
    end else if (enable) begin
      state        <= stateNxt;
      symCnt       <= symCntNxt;
      lfsr         <= lfsrNxt;
      dataOut      <= dataOutNxt;
      dataOutValid <= validNxt;
      sopOut       <= sopNxt;
      eopOut       <= eopNxt;
      parityFlag   <= parNxt;
      errOut       <= errNxt;
    end
  end

endmodule

// File: tb/tb_rs_encode_framer.sv
// Directed bench for rs_encode_framer: codewords are checked for data passthrough, framing flags
// and zero syndromes at a^0..a^5; parity of the unit-impulse frame is compared to hand-derived g(x).
module tb_rs_encode_framer;

  localparam int K    = 121;
  localparam int NPAR = 6;
  localparam int N    = K + NPAR;

  logic       CLK = 1'b0;
  logic       RESET, enable, sopIn, dataInValid;
  logic [6:0] dataIn;
  logic       inReady, dataOutValid, sopOut, eopOut, parityFlag, errOut;
  logic [6:0] dataOut;

  typedef struct packed {
    logic [6:0] dat;
    logic       sop;
    logic       eop;
    logic       par;
  } outT;

  outT        outQ[$];
  logic [6:0] frames [2][K];
  logic [6:0] lastPar [NPAR];
  logic [6:0] aPow [NPAR];
  // g(x) = x^6 + 3F x^5 + 10 x^4 + 4C x^3 + 24 x^2 + 4D x + 0B, expanded by hand
  logic [6:0] genExp [NPAR];
  int         passCnt = 0;
  int         totalCnt = 0;
  int         errCnt = 0;
  int         parSeen = 0;
  int         e0;

  always #5 CLK = ~CLK;

  rs_encode_framer dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .sopIn(sopIn),
    .dataInValid(dataInValid), .dataIn(dataIn), .inReady(inReady),
    .dataOut(dataOut), .dataOutValid(dataOutValid), .sopOut(sopOut),
    .eopOut(eopOut), .parityFlag(parityFlag), .errOut(errOut)
  );

  function automatic logic [6:0] bmul(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] p;
    logic [6:0] r;
    r = '0;
    p = {1'b0, a};
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r = r ^ p[6:0];
      p = p << 1;
      if (p[7]) p = p ^ 8'h89;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    logic en;
    en = enable;
    @(posedge CLK);
    #1;
    if (en && dataOutValid) begin
      outQ.push_back('{dat: dataOut, sop: sopOut, eop: eopOut, par: parityFlag});
      if (parityFlag) parSeen = parSeen + 1;
    end
    if (en && errOut) errCnt = errCnt + 1;
  endtask

  task automatic sendSym(input logic [6:0] d, input logic sop, input bit rnd);
    bit acc;
    acc         = 1'b0;
    dataIn      = d;
    sopIn       = sop;
    dataInValid = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      if (rnd) enable = ($urandom_range(0, 2) != 0);
      #1;
      acc = enable && inReady;
      cyc();
    end
    dataInValid = 1'b0;
    sopIn       = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    if (rnd && $urandom_range(0, 3) == 0) begin
      enable = 1'($urandom_range(0, 1));
      cyc();
    end
  endtask

  task automatic sendFrame(input int f, input int nSym, input bit rnd);
    for (int i = 0; i < nSym; i++) sendSym(frames[f][i], i == 0, rnd);
  endtask

  task automatic drain(input int n, input bit rnd);
    dataInValid = 1'b0;
    for (int t = 0; t < 400 && outQ.size() < n; t++) begin
      if (rnd) enable = 1'($urandom_range(0, 1));
      cyc();
    end
    enable = 1'b1;
  endtask

  task automatic checkCodeword(input int f, input string tag);
    logic [6:0]  s [NPAR];
    logic [41:0] syn;
    int          badDat, badFlag;
    outT         o;
    check($sformatf("%s_len", tag), 64'(outQ.size() >= N), 64'd1);
    if (outQ.size() < N) return;
    badDat  = 0;
    badFlag = 0;
    for (int j = 0; j < NPAR; j++) s[j] = '0;
    for (int i = 0; i < N; i++) begin
      o = outQ.pop_front();
      if (i < K && o.dat !== frames[f][i]) badDat++;
      if (i >= K) lastPar[i-K] = o.dat;
      if (o.sop !== (i == 0) || o.eop !== (i == N - 1) || o.par !== (i >= K)) badFlag++;
      for (int j = 0; j < NPAR; j++) s[j] = bmul(s[j], aPow[j]) ^ o.dat;
    end
    for (int j = 0; j < NPAR; j++) syn[j*7 +: 7] = s[j];
    check($sformatf("%s_data", tag), 64'(badDat), 64'd0);
    check($sformatf("%s_flags", tag), 64'(badFlag), 64'd0);
    check($sformatf("%s_syndromes", tag), 64'(syn), 64'd0);
  endtask

  initial begin
    logic [6:0] pz;
    int         badA;
    outT        o;
    genExp = '{7'h0B, 7'h4D, 7'h24, 7'h4C, 7'h10, 7'h3F};
    aPow[0] = 7'd1;
    for (int j = 1; j < NPAR; j++) aPow[j] = bmul(aPow[j-1], 7'd2);

    // Reset state
    RESET = 1'b1; enable = 1'b1; sopIn = 1'b0; dataInValid = 1'b0; dataIn = '0;
    #2 RESET = 1'b0;
    #1;
    check("rst_outputs", 64'({dataOut, dataOutValid, sopOut, eopOut, parityFlag, errOut}), 64'd0);
    check("rst_inReady_en1", 64'(inReady), 64'd1);
    cyc();
    cyc();
    RESET = 1'b1;
    enable = 1'b0;
    #1 check("inReady_en0", 64'(inReady), 64'd0);
    enable = 1'b1;
    #1 check("inReady_en1", 64'(inReady), 64'd1);

    // All-zero frame
    for (int i = 0; i < K; i++) frames[0][i] = '0;
    sendFrame(0, K, 0);
    drain(N, 0);
    checkCodeword(0, "zero");
    pz = '0;
    for (int i = 0; i < NPAR; i++) pz = pz | lastPar[i];
    check("zero_parity", 64'(pz), 64'd0);

    // Unit impulse at the last data position: parity is g(x) high to low
    frames[0][K-1] = 7'h01;
    sendFrame(0, K, 0);
    drain(N, 0);
    checkCodeword(0, "impulse");
    for (int i = 0; i < NPAR; i++)
      check($sformatf("impulse_par%0d", i), 64'(lastPar[i]), 64'(genExp[NPAR-1-i]));
    cyc();
    cyc();
    check("idle_hold_dataOut", 64'(dataOut), 64'h0B);
    check("idle_valid_low", 64'({dataOutValid, eopOut, parityFlag}), 64'd0);

    // Two random frames back to back at minimum spacing
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < K; i++) frames[f][i] = 7'($urandom_range(0, 127));
    sendFrame(0, K, 0);
    sendFrame(1, K, 0);
    drain(2 * N, 0);
    checkCodeword(0, "rnd0");
    checkCodeword(1, "rnd1");
    check("no_err_clean", 64'(errCnt), 64'd0);

    // Early sopIn at data symbol 50 aborts and restarts
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < K; i++) frames[f][i] = 7'($urandom_range(0, 127));
    outQ.delete();
    e0 = errCnt;
    sendFrame(0, 50, 0);
    sendFrame(1, K, 0);
    drain(50 + N, 0);
    check("abort_err", 64'(errCnt - e0), 64'd1);
    check("abort_len", 64'(outQ.size() >= 50 + N), 64'd1);
    badA = 0;
    for (int i = 0; i < 50 && outQ.size() > 0; i++) begin
      o = outQ.pop_front();
      if (o.dat !== frames[0][i] || o.sop !== (i == 0) || o.eop || o.par) badA++;
    end
    check("abort_partial", 64'(badA), 64'd0);
    checkCodeword(1, "restart");

    // Pseudo-random enable and input gaps
    for (int i = 0; i < K; i++) frames[0][i] = 7'($urandom_range(0, 127));
    outQ.delete();
    sendFrame(0, K, 1);
    drain(N, 1);
    checkCodeword(0, "gappy");

    // Reset during the third parity symbol
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < K; i++) frames[f][i] = 7'($urandom_range(0, 127));
    outQ.delete();
    enable = 1'b1;
    parSeen = 0;
    sendFrame(0, K, 0);
    for (int t = 0; t < 20 && parSeen < 3; t++) cyc();
    check("midpar_reached", 64'(parSeen), 64'd3);
    RESET = 1'b0;
    #1;
    check("midpar_rst_outputs", 64'({dataOut, dataOutValid, sopOut, eopOut, parityFlag, errOut}), 64'd0);
    check("midpar_rst_inReady", 64'(inReady), 64'd1);
    cyc();
    RESET = 1'b1;
    outQ.delete();
    e0 = errCnt;
    sendSym(7'h55, 1'b0, 0);
    cyc();
    cyc();
    check("orphan_err", 64'(errCnt - e0), 64'd1);
    check("orphan_no_output", 64'(outQ.size()), 64'd0);
    sendFrame(1, K, 0);
    drain(N, 0);
    checkCodeword(1, "post_reset");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
